// File: rtl/atm_session_driver.sv
// atm_session_driver: terminal-side initiator for ATM_controller. It accepts one
// session command (PIN, type, amount), presents the card and transaction type,
// strobes the PIN digits and the amount, and folds the controller's response
// flags into a single 3-bit status code reported with a one-cycle done pulse.
module atm_session_driver #(
    parameter int PIN_DIGITS   = 4,
    parameter int DIGIT_GAP    = 2,   // assumed >= 1
    parameter int PIN_WAIT     = 8,   // assumed >= 1
    parameter int RESP_TIMEOUT = 64   // assumed >= 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [4*PIN_DIGITS-1:0] cmd_pin,
    input  logic                    cmd_tipo,
    input  logic [31:0]             cmd_monto,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              status,
    output logic                    advert_seen,
    output logic                    tarjeta_recibida,
    output logic                    tipo_trans,
    output logic                    digito_stb,
    output logic [3:0]              digito,
    output logic                    monto_stb,
    output logic [31:0]             monto,
    input  logic                    balance_actualizado,
    input  logic                    entregar_dinero,
    input  logic                    pin_incorrecto,
    input  logic                    advertencia,
    input  logic                    bloqueo,
    input  logic                    fondos_insuficientes
);

    typedef enum logic [3:0] {
        S_IDLE, S_CARD, S_DIGIT, S_GAP, S_PIN_WAIT,
        S_AMT_GAP, S_AMT, S_RESULT, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        ST_OK_DEPOSIT  = 3'd0,
        ST_OK_WITHDRAW = 3'd1,
        ST_FUNDS_LOW   = 3'd2,
        ST_PIN_BAD     = 3'd3,
        ST_PIN_BAD_WARN = 3'd4,
        ST_BLOCKED     = 3'd5,
        ST_TIMEOUT     = 3'd6,
        ST_ABORTED     = 3'd7
    } status_t;

    // One shared cycle counter serves every timed state; it is sized for the
    // longest wait so it never wraps.
    localparam int CNT_MAX = (RESP_TIMEOUT > PIN_WAIT)
                           ? ((RESP_TIMEOUT > DIGIT_GAP) ? RESP_TIMEOUT : DIGIT_GAP)
                           : ((PIN_WAIT > DIGIT_GAP) ? PIN_WAIT : DIGIT_GAP);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int IDX_W = $clog2(PIN_DIGITS + 1);
    localparam int PIN_W = 4 * PIN_DIGITS;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DIGIT_GAP - 1);
    localparam logic [CNT_W-1:0] PIN_LAST  = CNT_W'(PIN_WAIT - 1);
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PIN_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PIN_W-1:0]  pin_q, pin_d;
    logic              tipo_q, tipo_d;
    logic [31:0]       monto_q, monto_d;
    logic              advert_q, advert_d;
    status_t           status_q, status_d;
    logic              advert_seen_q, advert_seen_d;
    logic              gap_done, in_window, end_sess;
    status_t           end_code;

    // State register and session context, synchronously cleared by rst.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples its _d value from the same pre-edge snapshot.
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            pin_q         <= '0;
            tipo_q        <= 1'b0;
            monto_q       <= '0;
            advert_q      <= 1'b0;
            status_q      <= ST_OK_DEPOSIT;
            advert_seen_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pin_q         <= pin_d;
            tipo_q        <= tipo_d;
            monto_q       <= monto_d;
            advert_q      <= advert_d;
            status_q      <= status_d;
            advert_seen_q <= advert_seen_d;
        end
    end

    // Next-state logic: sequencing, PIN-window monitoring, result decode, abort.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        pin_d         = pin_q;
        tipo_d        = tipo_q;
        monto_d       = monto_q;
        advert_d      = advert_q;
        status_d      = status_q;
        advert_seen_d = advert_seen_q;
        end_sess      = 1'b0;
        end_code      = ST_ABORTED;
        cnt_inc       = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
        gap_done      = (cnt_q == GAP_LAST);
        in_window     = (state_q == S_DIGIT) || (state_q == S_GAP) || (state_q == S_PIN_WAIT);

        if (state_q != S_IDLE && advertencia) begin
            advert_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    pin_d    = cmd_pin;
                    tipo_d   = cmd_tipo;
                    monto_d  = cmd_monto;
                    advert_d = 1'b0;
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = S_CARD;
                end
            end
            S_CARD, S_GAP: begin
                if (gap_done) begin
                    cnt_d   = '0;
                    state_d = S_DIGIT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DIGIT: begin
                // The digit on the bus is always the top nibble of the shifter.
                pin_d = pin_q << 4;
                idx_d = idx_q + IDX_ONE;
                cnt_d = '0;
                state_d = (idx_q == IDX_LAST) ? S_PIN_WAIT : S_GAP;
            end
            S_PIN_WAIT: begin
                if (cnt_q == PIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_AMT_GAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_AMT_GAP: begin
                if (gap_done) begin
                    cnt_d   = '0;
                    state_d = S_AMT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_AMT: begin
                cnt_d   = '0;
                state_d = S_RESULT;
            end
            S_RESULT: begin
                // A withdrawal is only complete once cash is handed out, so a
                // bare balance update keeps it waiting.
                if (bloqueo) begin
                    end_sess = 1'b1;
                    end_code = ST_BLOCKED;
                end else if (fondos_insuficientes) begin
                    end_sess = 1'b1;
                    end_code = ST_FUNDS_LOW;
                end else if (entregar_dinero) begin
                    end_sess = 1'b1;
                    end_code = ST_OK_WITHDRAW;
                end else if (balance_actualizado && !tipo_q) begin
                    end_sess = 1'b1;
                    end_code = ST_OK_DEPOSIT;
                end else if (cnt_q == RESP_LAST) begin
                    end_sess = 1'b1;
                    end_code = ST_TIMEOUT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // PIN rejection / lockout is watched from the first digit to the end
        // of the PIN wait; bloqueo outranks pin_incorrecto.
        if (in_window && (bloqueo || pin_incorrecto)) begin
            end_sess = 1'b1;
            if (bloqueo) begin
                end_code = ST_BLOCKED;
            end else if (advertencia || advert_q) begin
                end_code = ST_PIN_BAD_WARN;
            end else begin
                end_code = ST_PIN_BAD;
            end
        end

        if (abort && state_q != S_IDLE && state_q != S_DONE) begin
            end_sess = 1'b1;
            end_code = ST_ABORTED;
        end

        if (end_sess) begin
            state_d       = S_DONE;
            cnt_d         = '0;
            status_d      = end_code;
            advert_seen_d = advert_d;
        end
    end

    // Outputs decoded from state; abort masks a strobe due in the same cycle.
    assign cmd_ready        = (state_q == S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign tarjeta_recibida = busy && !done;
    assign tipo_trans       = tarjeta_recibida && tipo_q;
    assign digito_stb       = (state_q == S_DIGIT) && !abort;
    assign digito           = digito_stb ? pin_q[PIN_W-1 -: 4] : 4'd0;
    assign monto_stb        = (state_q == S_AMT) && !abort;
    assign monto            = monto_stb ? monto_q : 32'd0;
    assign status           = status_q;
    assign advert_seen      = advert_seen_q;

endmodule

// File: tb/tb_atm_session_driver.sv
// tb_atm_session_driver: directed sessions against atm_session_driver with a
// scripted controller, hand-computed strobe cycles and status codes.
module tb_atm_session_driver;

    localparam int PIN_DIGITS   = 4;
    localparam int DIGIT_GAP    = 2;
    localparam int PIN_WAIT     = 8;
    localparam int RESP_TIMEOUT = 64;
    localparam int MAX_CYC      = 200;
    localparam int R_NONE = 0, R_BAL = 1, R_ENT = 2, R_FON = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_pin;
    logic        cmd_tipo;
    logic [31:0] cmd_monto;
    logic        abort;
    logic        busy, done, advert_seen, tarjeta_recibida, tipo_trans;
    logic [2:0]  status;
    logic        digito_stb, monto_stb;
    logic [3:0]  digito;
    logic [31:0] monto;
    logic        balance_actualizado, entregar_dinero, pin_incorrecto;
    logic        advertencia, bloqueo, fondos_insuficientes;

    atm_session_driver #(
        .PIN_DIGITS(PIN_DIGITS), .DIGIT_GAP(DIGIT_GAP),
        .PIN_WAIT(PIN_WAIT), .RESP_TIMEOUT(RESP_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pin(cmd_pin),
        .cmd_tipo(cmd_tipo), .cmd_monto(cmd_monto), .abort(abort),
        .busy(busy), .done(done), .status(status), .advert_seen(advert_seen),
        .tarjeta_recibida(tarjeta_recibida), .tipo_trans(tipo_trans),
        .digito_stb(digito_stb), .digito(digito),
        .monto_stb(monto_stb), .monto(monto),
        .balance_actualizado(balance_actualizado), .entregar_dinero(entregar_dinero),
        .pin_incorrecto(pin_incorrecto), .advertencia(advertencia),
        .bloqueo(bloqueo), .fondos_insuficientes(fondos_insuficientes)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Records filled by the negedge monitor, cleared when a new session starts.
    int         sess_id = 0;
    int         mon_sess = 0;
    int         cur_cyc = 0;
    int         dig_cyc[$];
    logic [3:0] dig_val[$];
    int         monto_cyc = -1;
    int         n_monto = 0;
    logic [31:0] monto_val = '0;
    int         done_cyc = -1;
    logic [2:0] done_status = '0;
    logic       done_adv = 1'b0, done_card = 1'b0, done_tipo = 1'b0, done_stb = 1'b0;
    int         viol = 0;
    logic       prev_d = 1'b0, prev_m = 1'b0;
    logic       card1, tipo1;

    always @(negedge clk) begin
        if (mon_sess != sess_id) begin
            mon_sess = sess_id;
            dig_cyc.delete();
            dig_val.delete();
            monto_cyc = -1;
            n_monto   = 0;
            monto_val = '0;
            done_cyc  = -1;
        end
        if (digito_stb) begin
            dig_cyc.push_back(cur_cyc);
            dig_val.push_back(digito);
        end
        if (monto_stb) begin
            monto_cyc = cur_cyc;
            monto_val = monto;
            n_monto++;
        end
        if (digito_stb && monto_stb) viol++;
        if ((digito_stb && prev_d) || (monto_stb && prev_m)) viol++;
        if ((!digito_stb && digito != 4'd0) || (!monto_stb && monto != 32'd0)) viol++;
        prev_d = digito_stb;
        prev_m = monto_stb;
        if (done) begin
            done_cyc    = cur_cyc;
            done_status = status;
            done_adv    = advert_seen;
            done_card   = tarjeta_recibida;
            done_tipo   = tipo_trans;
            done_stb    = digito_stb | monto_stb;
        end
    end

    // Scenario knobs for the scripted controller.
    int          pin_dly, resp_sel, resp_dly, resp2_sel, resp2_dly, abort_at, rst_at, adv_at;
    logic        pin_adv, pin_blk;
    bit          hold_valid;

    task automatic clear_knobs();
        pin_dly = -1; pin_adv = 1'b0; pin_blk = 1'b0;
        resp_sel = R_NONE; resp_dly = 0; resp2_sel = R_NONE; resp2_dly = 0;
        abort_at = -1; rst_at = -1; adv_at = -1; hold_valid = 1'b0;
    endtask

    task automatic clear_resp();
        balance_actualizado = 1'b0; entregar_dinero = 1'b0; pin_incorrecto = 1'b0;
        advertencia = 1'b0; bloqueo = 1'b0; fondos_insuficientes = 1'b0; abort = 1'b0;
    endtask

    task automatic drive_resp(input int sel);
        case (sel)
            R_BAL:   balance_actualizado = 1'b1;
            R_ENT:   entregar_dinero = 1'b1;
            R_FON:   fondos_insuficientes = 1'b1;
            default: ;
        endcase
    endtask

    task automatic start_cmd(input logic [15:0] pin, input logic tipo, input logic [31:0] amt);
        cmd_pin = pin; cmd_tipo = tipo; cmd_monto = amt; cmd_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble the command bus so only latched values can reach the outputs.
        cmd_valid = 1'b0; cmd_pin = 16'hFFFF; cmd_tipo = ~tipo; cmd_monto = 32'h0;
    endtask

    // Cycle 1 is the first cycle after the accept edge.
    task automatic run_session();
        int last_dig;
        bit finished;
        finished = 1'b0;
        sess_id++;
        for (int c = 1; c <= MAX_CYC && !finished; c++) begin
            cur_cyc = c;
            clear_resp();
            if (c == 1) begin
                card1 = tarjeta_recibida;
                tipo1 = tipo_trans;
            end
            if (c > 1) begin
                last_dig = (dig_cyc.size() == PIN_DIGITS) ? dig_cyc[PIN_DIGITS-1] : -1;
                if (pin_dly > 0 && last_dig > 0 && c == last_dig + pin_dly) begin
                    pin_incorrecto = 1'b1; advertencia = pin_adv; bloqueo = pin_blk;
                end
                if (monto_cyc > 0 && c == monto_cyc + resp_dly) drive_resp(resp_sel);
                if (monto_cyc > 0 && c == monto_cyc + resp2_dly) drive_resp(resp2_sel);
            end
            if (c == adv_at) advertencia = 1'b1;
            if (c == abort_at) abort = 1'b1;
            if (hold_valid) begin
                cmd_valid = 1'b1; cmd_pin = 16'h5678; cmd_tipo = 1'b1; cmd_monto = 32'd42;
            end
            if (c == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            if (c == rst_at) begin
                rst = 1'b0;
                finished = 1'b1;
            end else if (done_cyc == c) begin
                finished = 1'b1;
            end
        end
        if (!finished) check("session_end_seen", 32'd0, 32'd1);
        clear_resp();
    endtask

    task automatic check_end(input string t, input int exp_cyc, input logic [2:0] exp_st,
                             input logic exp_adv, input int exp_ndig, input int exp_nm);
        check({t, ".done_cycle"}, done_cyc, exp_cyc);
        check({t, ".status"}, {29'd0, done_status}, {29'd0, exp_st});
        check({t, ".advert_seen"}, {31'd0, done_adv}, {31'd0, exp_adv});
        check({t, ".digit_count"}, dig_cyc.size(), exp_ndig);
        check({t, ".monto_count"}, n_monto, exp_nm);
        check({t, ".done_cycle_outputs"}, {29'd0, done_card, done_tipo, done_stb}, 32'd0);
        check({t, ".after_done"}, {30'd0, done, cmd_ready}, 32'd1);
        check({t, ".status_held"}, {29'd0, status}, {29'd0, exp_st});
    endtask

    task automatic check_digits(input string t, input logic [15:0] pin);
        logic [15:0] p;
        p = pin;
        for (int i = 0; i < dig_cyc.size(); i++) begin
            check({t, ".digit_cycle"}, dig_cyc[i], 3 + 3 * i);
            check({t, ".digit_value"}, {28'd0, dig_val[i]}, {28'd0, p[15:12]});
            p = p << 4;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_pin = '0; cmd_tipo = 1'b0; cmd_monto = '0;
        clear_resp();
        clear_knobs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset.flags", {24'd0, busy, done, advert_seen, tarjeta_recibida,
                              tipo_trans, digito_stb, monto_stb, 1'b0}, 32'd0);
        check("reset.status", {29'd0, status}, 32'd0);
        check("reset.buses", {28'd0, digito} | monto, 32'd0);

        // Deposit with correct PIN, balance update 3 cycles after the amount.
        clear_knobs(); resp_sel = R_BAL; resp_dly = 3;
        start_cmd(16'h1234, 1'b0, 32'd500);
        run_session();
        check("dep.card_type_c1", {30'd0, card1, tipo1}, 32'd2);
        check_digits("dep", 16'h1234);
        check("dep.monto_cycle", monto_cyc, 23);
        check("dep.monto_value", monto_val, 32'd500);
        check_end("dep", 27, 3'd0, 1'b0, 4, 1);

        // Withdrawal, insufficient funds.
        clear_knobs(); resp_sel = R_FON; resp_dly = 2;
        start_cmd(16'h1234, 1'b1, 32'hFFFF_FFFF);
        run_session();
        check("funds.card_type_c1", {30'd0, card1, tipo1}, 32'd3);
        check("funds.monto_value", monto_val, 32'hFFFF_FFFF);
        check_end("funds", 26, 3'd2, 1'b0, 4, 1);

        // Withdrawal: balance update alone keeps waiting for cash delivery.
        clear_knobs(); resp_sel = R_BAL; resp_dly = 1; resp2_sel = R_ENT; resp2_dly = 4;
        start_cmd(16'h4321, 1'b1, 32'd60);
        run_session();
        check_digits("wd", 16'h4321);
        check_end("wd", 28, 3'd1, 1'b0, 4, 1);

        // Wrong PIN two cycles after the last digit.
        clear_knobs(); pin_dly = 2;
        start_cmd(16'h1234, 1'b0, 32'd10);
        run_session();
        check_end("pin", 15, 3'd3, 1'b0, 4, 0);

        // Wrong PIN together with advertencia.
        clear_knobs(); pin_dly = 2; pin_adv = 1'b1;
        start_cmd(16'h1234, 1'b0, 32'd10);
        run_session();
        check_end("warn", 15, 3'd4, 1'b1, 4, 0);

        // bloqueo and pin_incorrecto together: lockout wins.
        clear_knobs(); pin_dly = 2; pin_blk = 1'b1;
        start_cmd(16'h1234, 1'b0, 32'd10);
        run_session();
        check_end("blk", 15, 3'd5, 1'b0, 4, 0);

        // No response at all: timeout RESP_TIMEOUT+1 cycles after the amount.
        clear_knobs();
        start_cmd(16'h1234, 1'b0, 32'd77);
        run_session();
        check("tmo.latency", done_cyc - monto_cyc, RESP_TIMEOUT + 1);
        check_end("tmo", 88, 3'd6, 1'b0, 4, 1);

        // Abort on the first digit cycle: that strobe never appears.
        clear_knobs(); abort_at = 3;
        start_cmd(16'h1234, 1'b0, 32'd5);
        run_session();
        check_end("abd", 4, 3'd7, 1'b0, 0, 0);

        // Abort in the second gap while a new command is held on the bus.
        clear_knobs(); abort_at = 7; hold_valid = 1'b1;
        start_cmd(16'h1234, 1'b0, 32'd5);
        run_session();
        check_digits("abg", 16'h1234);
        check_end("abg", 8, 3'd7, 1'b0, 2, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_pin = 16'hFFFF; cmd_tipo = 1'b0; cmd_monto = '0;

        // Held command is accepted right after the aborted session; balance
        // update alone does not end a withdrawal, so it times out.
        clear_knobs(); resp_sel = R_BAL; resp_dly = 2; adv_at = 2;
        run_session();
        check("follow.card_type_c1", {30'd0, card1, tipo1}, 32'd3);
        check_digits("follow", 16'h5678);
        check("follow.monto_value", monto_val, 32'd42);
        check_end("follow", 88, 3'd6, 1'b1, 4, 1);

        // Reset in the middle of RESULT.
        clear_knobs(); rst_at = 28;
        start_cmd(16'h1234, 1'b1, 32'd99);
        run_session();
        check("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst.flags", {24'd0, busy, done, advert_seen, tarjeta_recibida,
                            tipo_trans, digito_stb, monto_stb, 1'b0}, 32'd0);
        check("rst.status", {29'd0, status}, 32'd0);
        check("rst.buses", {28'd0, digito} | monto, 32'd0);
        clear_knobs(); resp_sel = R_BAL; resp_dly = 1;
        start_cmd(16'h9ABC, 1'b0, 32'd7);
        check("rst.no_done", done_cyc, -1);
        run_session();
        check_digits("post_rst", 16'h9ABC);
        check("post_rst.monto_value", monto_val, 32'd7);
        check_end("post_rst", 25, 3'd0, 1'b0, 4, 1);

        check("strobe_rules", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/atm_session_driver.md
Name: atm_session_driver

Overview:
- Synthesizable terminal-side initiator for `ATM_controller`: it drives card, transaction-type, PIN-digit and amount strobes, and interprets the controller's response flags.
- A host issues one session command (PIN, type, amount). The block runs the full exchange and returns a single status code.
- Used as the card-reader/keypad front end in integrated builds, and as a self-checking stimulus source in place of the hand-written tester.

Parameters:
- PIN_DIGITS, 4, number of 4-bit PIN digits sent per session.
- DIGIT_GAP, 2, idle cycles before each digit strobe and before the amount strobe.
- PIN_WAIT, 8, cycles after the last digit strobe spent watching for pin_incorrecto/bloqueo.
- RESP_TIMEOUT, 64, maximum cycles waited for a transaction result after monto_stb.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  host command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&&cmd_ready
- cmd_pin  in  4*PIN_DIGITS  PIN digits, most significant nibble sent first
- cmd_tipo  in  1  0=deposit, 1=withdrawal
- cmd_monto  in  32  transaction amount
- abort  in  1  cancel current session
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the session ends
- status  out  3  result code, valid from the done cycle and held until the next done
- advert_seen  out  1  advertencia was observed during the last session; updated with done
- tarjeta_recibida  out  1  card present to the controller
- tipo_trans  out  1  transaction type to the controller
- digito_stb  out  1  one-cycle digit strobe
- digito  out  4  digit value; 0 when digito_stb is low
- monto_stb  out  1  one-cycle amount strobe
- monto  out  32  amount; 0 when monto_stb is low
- balance_actualizado, entregar_dinero, pin_incorrecto, advertencia, bloqueo, fondos_insuficientes  in  1 each  controller responses

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1. State returns to IDLE and all counters clear. Reset mid-session drops tarjeta_recibida the next cycle and emits no done.
- Status codes:
  - 0 OK_DEPOSIT
  - 1 OK_WITHDRAW
  - 2 FUNDS_LOW
  - 3 PIN_BAD
  - 4 PIN_BAD_WARN (pin_incorrecto with advertencia)
  - 5 BLOCKED
  - 6 TIMEOUT
  - 7 ABORTED
- On accept, the block latches cmd_pin, cmd_tipo and cmd_monto. Command inputs are ignored while busy.
- **IDLE** -> CARD on accept. In CARD, tarjeta_recibida=1 and tipo_trans=latched type; both are held until DONE.
- **CARD**: DIGIT_GAP cycles, then DIGIT.
- **DIGIT**: one cycle with digito_stb=1 and digito=current nibble, index incremented. Next state is GAP if more digits remain, else PIN_WAIT. First strobe occurs DIGIT_GAP+1 cycles after accept.
- **GAP**: DIGIT_GAP cycles with no strobe, then DIGIT.
- **PIN_WAIT**: counts PIN_WAIT cycles. When the count expires with no error, go to AMT_GAP.
- **Monitoring window**: from the first DIGIT cycle through the end of PIN_WAIT, inputs are sampled every cycle.
  - bloqueo -> DONE with BLOCKED.
  - Otherwise pin_incorrecto -> DONE with PIN_BAD, or PIN_BAD_WARN if advertencia is high in the same cycle or was seen earlier in this session.
  - bloqueo wins over pin_incorrecto when both are high in the same cycle.
- **AMT_GAP**: DIGIT_GAP cycles, then AMT.
- **AMT**: one cycle with monto_stb=1 and monto=latched amount, then RESULT.
- **RESULT**: samples every cycle for up to RESP_TIMEOUT cycles. Priority in the same cycle:
  - bloqueo -> BLOCKED
  - fondos_insuficientes -> FUNDS_LOW
  - entregar_dinero -> OK_WITHDRAW
  - balance_actualizado -> OK_DEPOSIT for a deposit. For a withdrawal, balance_actualizado alone is not terminal; the block keeps waiting for entregar_dinero.
  - No result before the count expires -> TIMEOUT.
- **DONE**: one cycle. done=1, status and advert_seen registered, tarjeta_recibida=0, tipo_trans=0. Then IDLE; cmd_ready returns the cycle after done.
- **abort** high in any state other than IDLE/DONE: next state is DONE with ABORTED, and any strobe scheduled for that cycle is suppressed. abort in IDLE is ignored.
- advertencia high in any busy cycle sets the internal advert flag, which clears on accept.
- Strobes never overlap. digito_stb and monto_stb are never high in the same cycle, and each is never high for 2 consecutive cycles.
- Counters are sized for the parameter values with no wrap. The PIN_WAIT and RESP_TIMEOUT counters saturate at their terminal count.

Test Plan:
- **Deposit, correct PIN:** cmd_pin=0x1234, tipo=0, monto=500, controller pulses balance_actualizado 3 cycles after monto_stb -> digits 1,2,3,4 strobed on cycles 3,6,9,12 after accept, monto_stb with monto=500, then done with status=0.
- **Withdrawal, insufficient funds:** tipo=1, monto=0xFFFFFFFF, controller asserts fondos_insuficientes -> status=2, tarjeta_recibida low in the done cycle.
- **Wrong PIN:**
  - pin_incorrecto 2 cycles after the 4th digit -> status=3, no monto_stb ever.
  - Repeat with advertencia pulsed together with pin_incorrecto -> status=4, advert_seen=1.
  - bloqueo and pin_incorrecto high in the same cycle -> status=5.
- **Timeout:** no response after monto_stb -> done exactly RESP_TIMEOUT+1 cycles after the strobe, status=6.
- **Abort:** abort asserted during the 2nd GAP -> next cycle done with status=7, no further strobes. cmd_valid held during busy is ignored, then accepted the cycle after done+1.
- **Reset:** rst asserted mid-RESULT -> next cycle all outputs 0, cmd_ready=1, no done pulse. A new command then completes normally.
